// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Constants shared by the core register file and the register dump walker:
//   register count, data width, index width and the dump FSM state encoding.
//   Also holds a small helper that recognises the last register index.
// ---------------------------------------------------------------------------
package regfile_pkg;

  // Number of architectural registers walked by a dump (indices 0..REGNUM-1)
  localparam int REGNUM  = 32;
  // Register data width
  localparam int WIDTH   = 32;
  // Register index width; REGNUM must fit in 2**KEY_LEN
  localparam int KEY_LEN = 5;
  // Walk counter width: one extra bit so the counter can hold REGNUM itself
  localparam int IDX_W   = KEY_LEN + 1;

  // Index of the final register visited during a walk
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REGNUM - 1);

  // Dump controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } dumpState_t;

  // True when the walk counter points at the last register
  function automatic logic isLastIdx(input logic [IDX_W-1:0] idx);
    return idx == LAST_IDX;
  endfunction

endpackage

// File: rtl/regfile_dump_ostage.sv
// ---------------------------------------------------------------------------
// regfile_dump_ostage
//   One-entry valid/ready holding register for (index, value) pairs produced
//   by the register dump walker.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset; empties the slot, clears payload
//   i_load    capture i_idx/i_data and mark the slot valid
//   i_ready   downstream sink accepts the current pair when o_valid is high
//   i_idx     register index to capture
//   i_data    register value to capture
//   o_valid   slot holds a pair
//   o_idx     index of the held pair
//   o_data    value of the held pair
//   o_fire    handshake this cycle (o_valid && i_ready)
// ---------------------------------------------------------------------------
module regfile_dump_ostage
  import regfile_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_ready,
  input  logic [KEY_LEN-1:0] i_idx,
  input  logic [WIDTH-1:0]   i_data,
  output logic               o_valid,
  output logic [KEY_LEN-1:0] o_idx,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_fire
);

  logic               r_valid;
  logic [KEY_LEN-1:0] r_idx;
  logic [WIDTH-1:0]   r_data;

  // A load in the same cycle as a handshake refills the slot instead of
  // emptying it, which is what gives one pair per cycle with ready held high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload only moves on a load, so a stalled pair stays put.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_data <= '0;
    end else if (i_load) begin
      r_idx  <= i_idx;
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_idx   = r_idx;
  assign o_data  = r_data;
  assign o_fire  = r_valid && i_ready;

endmodule

// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
//   Sequential reader for the register file. A start pulse sampled while idle
//   walks every register through one read port and streams (index, value)
//   pairs over a valid/ready channel. The core keeps running during a dump,
//   so each value is whatever the register holds in the cycle it is read.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset; aborts any dump in progress
//   i_start      dump request, only honoured while idle
//   o_busy       dump in progress
//   o_readreg    index driven onto the register file read port
//   i_rdata      register file read data, combinational from o_readreg
//   o_out_valid  output pair valid
//   i_out_ready  sink accepts the pair when o_out_valid && i_out_ready
//   o_out_idx    register index of the current pair
//   o_out_data   register value of the current pair
//   o_done       one-cycle pulse after the last pair is accepted
//   o_csum       (REGFILE_DUMP_CSUM_EN only) XOR of all accepted values in
//                the current dump; valid at o_done, held until next start
//
// Configuration
//   REGFILE_DUMP_CSUM_EN  adds the o_csum port and its accumulator
// ---------------------------------------------------------------------------
module regfile_dump
  import regfile_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic               o_busy,
  output logic [KEY_LEN-1:0] o_readreg,
  input  logic [WIDTH-1:0]   i_rdata,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [KEY_LEN-1:0] o_out_idx,
  output logic [WIDTH-1:0]   o_out_data,
  output logic               o_done
`ifdef REGFILE_DUMP_CSUM_EN
  ,
  output logic [WIDTH-1:0]   o_csum
`endif
);

  dumpState_t       r_state;
  dumpState_t       w_nextState;
  logic [IDX_W-1:0] r_rdIdx;
  logic             r_done;
  logic             w_load;
  logic             w_fire;
  logic             w_startAccept;
  logic             w_doneNext;
  logic             w_outValid;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A start arriving while the done pulse is still high is
  // dropped, so a new dump always needs start seen in a quiet idle cycle.
  // In READ the output slot is refilled whenever it is empty or draining.
  always_comb begin
    w_nextState   = r_state;
    w_startAccept = 1'b0;
    w_doneNext    = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !r_done) begin
          w_startAccept = 1'b1;
          w_nextState   = READ;
        end
      end
      READ: begin
        w_load = !w_outValid || i_out_ready;
        if (w_load && isLastIdx(r_rdIdx)) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (w_fire) begin
          w_nextState = IDLE;
          w_doneNext  = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Walk counter. It advances only on loads, and the last load also leaves
  // READ, so it parks at REGNUM and never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdIdx <= '0;
    end else if (w_startAccept) begin
      r_rdIdx <= '0;
    end else if (w_load) begin
      r_rdIdx <= r_rdIdx + IDX_W'(1);
    end
  end

  // Done pulse, registered so it lines up with busy falling.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_doneNext;
    end
  end

  regfile_dump_ostage u_ostage (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_ready (i_out_ready),
    .i_idx   (r_rdIdx[KEY_LEN-1:0]),
    .i_data  (i_rdata),
    .o_valid (w_outValid),
    .o_idx   (o_out_idx),
    .o_data  (o_out_data),
    .o_fire  (w_fire)
  );

`ifdef REGFILE_DUMP_CSUM_EN
  logic [WIDTH-1:0] r_csum;

  // Running XOR of accepted values; cleared when a dump is accepted so the
  // previous result stays visible until then.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csum <= '0;
    end else if (w_startAccept) begin
      r_csum <= '0;
    end else if (w_fire) begin
      r_csum <= r_csum ^ o_out_data;
    end
  end

  assign o_csum = r_csum;
`endif

  assign o_busy      = (r_state != IDLE);
  assign o_readreg   = (r_state == READ) ? r_rdIdx[KEY_LEN-1:0] : '0;
  assign o_out_valid = w_outValid;
  assign o_done      = r_done;

endmodule
